// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data port has priority, bounded by a fairness
// counter so a waiting instruction fetch is granted after FAIR_MAX data grants.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FAIR_MAX = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              err
);

  localparam int unsigned FW = $clog2(FAIR_MAX + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FAIR_LIM  = FW'(FAIR_MAX);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic [FW-1:0]     fair_q, fair_d;
  logic [WW-1:0]     wait_q, wait_d;

  logic              dm_win, if_win;
  logic              finish;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = 1'b0;
    fair_d     = fair_q;
    wait_d     = wait_q;
    finish     = 1'b0;
    rd_val     = '0;

    // Priority is decided on raw requests; a winner still showing its done
    // pulse is simply not granted this cycle, so the loser does not jump in.
    dm_win = dm_req && ((fair_q < FAIR_LIM) || !if_req);
    if_win = !dm_win && if_req;

    case (state_q)
      IDLE: begin
        if (dm_win && !dm_done_q) begin
          state_d = DM_BUSY;
          addr_d  = dm_addr;
          wr_d    = dm_wr;
          wdata_d = dm_wdata;
          wait_d  = '0;
          if (if_req && (fair_q < FAIR_LIM)) fair_d = fair_q + 1'b1;
        end else if (if_win && !if_done_q) begin
          state_d = IF_BUSY;
          addr_d  = if_addr;
          wr_d    = 1'b0;
          wdata_d = '0;
          wait_d  = '0;
          fair_d  = '0;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (!mem_rdy) wait_d = wait_q + 1'b1;
        finish = mem_rdy || (wait_q == WAIT_LAST);
        if (finish) begin
          rd_val  = (mem_rdy && !wr_q) ? mem_rdata : '0;
          err_d   = !mem_rdy;
          state_d = IDLE;
          wr_d    = 1'b0;
          if (state_q == IF_BUSY) begin
            if_done_d  = 1'b1;
            if_rdata_d = rd_val;
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = rd_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!if_req) fair_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
      fair_q     <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
      fair_q     <= fair_d;
      wait_q     <= wait_d;
    end
  end

  assign mem_en    = (state_q != IDLE);
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-requester transactions plus
// hand sequences for arbitration order, fairness, idle mem_rdy and reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_wr, mem_rdy;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, mem_en, mem_wr, err;

  int unsigned passed = 0;
  int unsigned total  = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FAIR_MAX(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    int          delay;     // busy cycle index (0-based) at which mem_rdy rises
    logic [15:0] rdata;
    logic        exp_dm;
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int j;
    logic [15:0] rd_exp;
    if_req = v.if_req; if_addr = v.if_addr;
    dm_req = v.dm_req; dm_wr = v.dm_wr; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    mem_rdy = 1'b0; mem_rdata = v.rdata;
    step();
    chk($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'd1);
    chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.exp_addr));
    chk($sformatf("v%0d mem_wr", idx), 32'(mem_wr), 32'(v.exp_wr));
    if (v.exp_dm) chk($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(v.exp_wdata));
    j = 0;
    while (mem_en && j < 40) begin
      mem_rdy = (j == v.delay);
      step();
      j++;
    end
    mem_rdy = 1'b0;
    chk($sformatf("v%0d busy_cycles", idx), 32'(j), 32'(v.exp_cyc));
    chk($sformatf("v%0d if_done", idx), 32'(if_done), 32'(!v.exp_dm));
    chk($sformatf("v%0d dm_done", idx), 32'(dm_done), 32'(v.exp_dm));
    chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d rdata", idx), 32'(v.exp_dm ? dm_rdata : if_rdata), 32'(v.exp_rdata));
    if_req = 1'b0; dm_req = 1'b0;
    step();
    chk($sformatf("v%0d done_low", idx), 32'({if_done, dm_done, err}), 32'd0);
    rd_exp = v.exp_rdata;
    chk($sformatf("v%0d rdata_hold", idx), 32'(v.exp_dm ? dm_rdata : if_rdata), 32'(rd_exp));
  endtask

  logic got[10];
  logic exp_pat[10];

  initial begin
    //            ifr ifaddr    dmr wr dmaddr    wdata    dly rdata     dm wr addr      wdata     rdata     err cyc
    vecs[0] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,  16'hBEEF, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 1};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 2,  16'hA5A5, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'hA5A5, 1'b0, 3};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0300, 16'h5555, 0,  16'hFFFF, 1'b1, 1'b1, 16'h0300, 16'h5555, 16'h0000, 1'b0, 1};
    vecs[3] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 14, 16'h1357, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1357, 1'b0, 15};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 99, 16'h2468, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1, 15};
    vecs[5] = '{1'b1, 16'h1234, 1'b0, 1'b1, 16'h0000, 16'hAAAA, 1,  16'h0F0F, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0F0F, 1'b0, 2};
    vecs[6] = '{1'b1, 16'h0ABC, 1'b0, 1'b0, 16'h0000, 16'h0000, 99, 16'h3333, 1'b0, 1'b0, 16'h0ABC, 16'h0000, 16'h0000, 1'b1, 15};
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; mem_rdy = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #3;
    chk("reset_outputs", 32'(|{mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done,
                               if_rdata, dm_rdata, err}), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // mem_rdy pulsed while idle must not produce any completion
    mem_rdy = 1'b1; mem_rdata = 16'h7777;
    step(); step();
    mem_rdy = 1'b0;
    chk("idle_rdy_ignored", 32'({mem_en, if_done, dm_done, err}), 32'd0);

    // Simultaneous requests: the store goes first, fetch follows
    if_req = 1'b1; if_addr = 16'h0080;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
    step();
    chk("both_first_addr", 32'(mem_addr), 32'h0100);
    chk("both_first_wr", 32'({mem_en, mem_wr}), 32'b11);
    chk("both_first_wdata", 32'(mem_wdata), 32'h1234);
    mem_rdy = 1'b1; mem_rdata = 16'hCAFE;
    step();
    mem_rdy = 1'b0;
    chk("both_dm_done", 32'({dm_done, if_done, err}), 32'b100);
    chk("both_dm_rdata", 32'(dm_rdata), 32'h0000);
    dm_req = 1'b0; dm_wr = 1'b0;
    step();
    chk("both_if_grant", 32'({mem_en, mem_wr, mem_addr}), {14'd0, 1'b1, 1'b0, 16'h0080});
    mem_rdy = 1'b1; mem_rdata = 16'h4242;
    step();
    mem_rdy = 1'b0;
    chk("both_if_done", 32'({if_done, if_rdata}), {15'd0, 1'b1, 16'h4242});
    if_req = 1'b0;
    step(); step();

    // Fairness: both requesters always asking, single-cycle memory
    begin
      int n;
      n = 0;
      if_req = 1'b1; if_addr = 16'h1000;
      dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'hD000; dm_wdata = 16'h0001;
      mem_rdy = 1'b1; mem_rdata = 16'h0000;
      for (int c = 0; c < 80 && n < 10; c++) begin
        step();
        if (mem_en) begin
          got[n] = (mem_addr == 16'hD000);
          n++;
        end
      end
      chk("fair_grant_count", 32'(n), 32'd10);
      for (int k = 0; k < 10; k++)
        chk($sformatf("fair_grant%0d_is_dm", k), 32'(got[k]), 32'(exp_pat[k]));
      if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
      step();
      mem_rdy = 1'b0;
      step(); step(); step();
    end

    // Reset in the middle of a data access abandons it; held request re-granted
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0555;
    step();
    chk("rst_seq_busy", 32'({mem_en, mem_addr}), {15'd0, 1'b1, 16'h0555});
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'(|{mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done,
                                   if_rdata, dm_rdata, err}), 32'd0);
    step();
    chk("rst_no_done", 32'(dm_done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_regrant", 32'({mem_en, mem_addr}), {15'd0, 1'b1, 16'h0555});
    mem_rdy = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_rdy = 1'b0;
    chk("rst_regrant_done", 32'({dm_done, dm_rdata}), {15'd0, 1'b1, 16'h9999});
    dm_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
